// File: rtl/decompress_csr.sv
// decompress_csr: walks a CSR matrix held in three synchronous-read memories and
// streams the dense H_OUT x W_OUT matrix row-major over a valid/ready interface.
module decompress_csr #(
  parameter int H_OUT         = 7,
  parameter int W_OUT         = 8,
  parameter int SIZE_OUT      = 80,
  parameter int SIZE_val_DATA = 8,
  parameter int SIZE_col_DATA = 10,
  parameter int SIZE_row_DATA = 18,
  parameter int SIZE_in_DATA  = 14
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic [$clog2(H_OUT+1)-1:0]      ptr_addr,
  input  logic [SIZE_row_DATA-1:0]        ptr_data,
  output logic [$clog2(SIZE_OUT)-1:0]     nz_addr,
  input  logic [SIZE_col_DATA-1:0]        col_data,
  input  logic signed [SIZE_val_DATA-1:0] val_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [SIZE_in_DATA-1:0]  out_data,
  output logic [$clog2(H_OUT)-1:0]        out_row,
  output logic [$clog2(W_OUT)-1:0]        out_col,
  output logic                            out_last,
  output logic                            done,
  output logic                            err
);

  localparam int PAW = $clog2(H_OUT+1);
  localparam int NAW = $clog2(SIZE_OUT);
  localparam int RW  = $clog2(H_OUT);
  localparam int CW  = $clog2(W_OUT);

  localparam logic [RW-1:0]            R_LAST = RW'(H_OUT-1);
  localparam logic [CW-1:0]            C_LAST = CW'(W_OUT-1);
  localparam logic [SIZE_col_DATA-1:0] W_COL  = SIZE_col_DATA'(W_OUT);
  localparam logic [SIZE_row_DATA-1:0] NZ_CAP = SIZE_row_DATA'(SIZE_OUT);

  typedef enum logic [2:0] {IDLE, P0, PEND, CHK, NZ, EMIT, DONE} state_t;

  state_t                     state;
  logic [RW-1:0]              r;
  logic [CW-1:0]              c;
  logic [SIZE_row_DATA-1:0]   k;
  logic [SIZE_row_DATA-1:0]   row_end;
  logic [SIZE_col_DATA-1:0]   nz_col;
  logic [SIZE_val_DATA-1:0]   nz_val;
  logic                       nz_hit;

  logic [SIZE_col_DATA-1:0]   c_ext;
  logic [CW-1:0]              c_nxt;
  logic                       hit_now;
  logic                       nxt_hit;
  logic [SIZE_row_DATA-1:0]   k_adv;
  logic                       at_last;
  logic                       nxt_last;

  function automatic logic [SIZE_in_DATA-1:0] sext(input logic [SIZE_val_DATA-1:0] v);
    return {{(SIZE_in_DATA-SIZE_val_DATA){v[SIZE_val_DATA-1]}}, v};
  endfunction

  always_comb begin
    c_ext    = SIZE_col_DATA'(c);
    c_nxt    = c + CW'(1);
    hit_now  = nz_hit && (nz_col == c_ext);
    nxt_hit  = nz_hit && (nz_col == SIZE_col_DATA'(c_nxt));
    k_adv    = hit_now ? k + SIZE_row_DATA'(1) : k;
    at_last  = (r == R_LAST) && (c == C_LAST);
    nxt_last = (r == R_LAST) && (c_nxt == C_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr_addr  <= '0;
      nz_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      r         <= '0;
      c         <= '0;
      k         <= '0;
      row_end   <= '0;
      nz_col    <= '0;
      nz_val    <= '0;
      nz_hit    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            ptr_addr <= '0;
            err      <= 1'b0;
            state    <= P0;
          end
        end
        P0: begin
          k        <= ptr_data;
          r        <= '0;
          ptr_addr <= PAW'(1);
          state    <= PEND;
        end
        PEND: begin
          c <= '0;
          // A bad row pointer collapses the row to empty and leaves k untouched.
          if ((ptr_data < k) || (ptr_data > NZ_CAP)) begin
            err     <= 1'b1;
            row_end <= k;
          end else begin
            row_end <= ptr_data;
          end
          state <= CHK;
        end
        CHK: begin
          if (k < row_end) begin
            nz_addr <= NAW'(k);
            state   <= NZ;
          end else begin
            nz_hit    <= 1'b0;
            out_valid <= 1'b1;
            out_row   <= r;
            out_col   <= c;
            out_data  <= '0;
            out_last  <= at_last;
            state     <= EMIT;
          end
        end
        NZ: begin
          nz_col <= col_data;
          nz_val <= val_data;
          if ((col_data >= W_COL) || (col_data < c_ext)) begin
            err   <= 1'b1;
            k     <= k + SIZE_row_DATA'(1);
            state <= CHK;
          end else begin
            nz_hit    <= 1'b1;
            out_valid <= 1'b1;
            out_row   <= r;
            out_col   <= c;
            out_data  <= (col_data == c_ext) ? sext(val_data) : '0;
            out_last  <= at_last;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (c == C_LAST) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (k_adv < row_end) begin
                err <= 1'b1;
                k   <= row_end;
              end else begin
                k <= k_adv;
              end
              if (r == R_LAST) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                r        <= r + RW'(1);
                ptr_addr <= PAW'(r) + PAW'(2);
                state    <= PEND;
              end
            end else if (hit_now) begin
              k         <= k_adv;
              c         <= c_nxt;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= CHK;
            end else begin
              // Pending nonzero lies further right (or row is exhausted): stream zeros.
              c        <= c_nxt;
              out_col  <= c_nxt;
              out_data <= nxt_hit ? sext(nz_val) : '0;
              out_last <= nxt_last;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decompress_csr.sv
// tb_decompress_csr: CSR matrices (directed and random) decoded by a row-by-row
// reference; expected elements are queued at start and popped by a handshake monitor.
`timescale 1ns/1ps
module tb_decompress_csr;

  localparam int H   = 7;
  localparam int W   = 8;
  localparam int NZC = 80;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               out_ready;
  logic [2:0]         ptr_addr;
  logic [17:0]        ptr_data;
  logic [6:0]         nz_addr;
  logic [9:0]         col_data;
  logic signed [7:0]  val_data;
  logic               out_valid;
  logic signed [13:0] out_data;
  logic [2:0]         out_row;
  logic [2:0]         out_col;
  logic               out_last;
  logic               done;
  logic               err;

  logic [17:0] ptr_mem [0:H];
  logic [9:0]  col_mem [0:NZC-1];
  logic [7:0]  val_mem [0:NZC-1];

  typedef struct packed {
    logic [2:0]  row;
    logic [2:0]  col;
    logic [13:0] data;
    logic        last;
  } item_t;

  item_t exp_q[$];
  bit    exp_err;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    hs_count = 0;
  bit    ready_rand = 1'b0;

  always #5 clk = ~clk;

  decompress_csr #(
    .H_OUT(H), .W_OUT(W), .SIZE_OUT(NZC), .SIZE_val_DATA(8),
    .SIZE_col_DATA(10), .SIZE_row_DATA(18), .SIZE_in_DATA(14)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .ptr_addr(ptr_addr), .ptr_data(ptr_data),
    .nz_addr(nz_addr), .col_data(col_data), .val_data(val_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .done(done), .err(err)
  );

  // The DUT's registered address acts as the memory's address register, so the
  // word appears the cycle after the address is issued.
  assign ptr_data = ptr_mem[ptr_addr];
  assign col_data = (nz_addr < 7'd80) ? col_mem[nz_addr] : '0;
  assign val_data = (nz_addr < 7'd80) ? val_mem[nz_addr] : '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decoder: dense rows built from the CSR rules, pushed as 56 items.
  task automatic build_expect();
    int kk, re, last_col, cc, v;
    logic [13:0] dense [W];
    item_t it;
    exp_q.delete();
    exp_err = 1'b0;
    kk = int'(ptr_mem[0]);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) dense[c] = '0;
      re = int'(ptr_mem[r+1]);
      if (re < kk || re > NZC) begin
        exp_err = 1'b1;
        re = kk;
      end
      last_col = -1;
      for (int j = kk; j < re; j++) begin
        if (last_col == W-1) begin
          exp_err = 1'b1;
          break;
        end
        cc = int'(col_mem[j]);
        if (cc >= W || cc <= last_col) begin
          exp_err = 1'b1;
          continue;
        end
        v = $signed(val_mem[j]);
        dense[cc] = v[13:0];
        last_col = cc;
      end
      kk = re;
      for (int c = 0; c < W; c++) begin
        it.row  = 3'(r);
        it.col  = 3'(c);
        it.data = dense[c];
        it.last = (r == H-1) && (c == W-1);
        exp_q.push_back(it);
      end
    end
  endtask

  task automatic clear_mems();
    for (int i = 0; i <= H; i++) ptr_mem[i] = '0;
    for (int i = 0; i < NZC; i++) begin
      col_mem[i] = 10'($urandom_range(0, 1023));
      val_mem[i] = 8'($urandom);
    end
  endtask

  task automatic gen_identity();
    clear_mems();
    for (int i = 0; i <= H; i++) ptr_mem[i] = 18'(i);
    for (int i = 0; i < H; i++) begin
      col_mem[i] = 10'(i);
      val_mem[i] = 8'(i + 1);
    end
  endtask

  task automatic gen_neg();
    clear_mems();
    for (int i = 0; i <= H; i++) ptr_mem[i] = (i <= 3) ? 18'd4 : 18'd5;
    col_mem[4] = 10'd5;
    val_mem[4] = 8'h80;
  endtask

  task automatic gen_unsorted();
    clear_mems();
    for (int i = 0; i <= H; i++) ptr_mem[i] = (i <= 2) ? 18'd0 : 18'd2;
    col_mem[0] = 10'd4; val_mem[0] = 8'h25;
    col_mem[1] = 10'd1; val_mem[1] = 8'h33;
  endtask

  task automatic gen_sorted(input int nnz);
    bit used [H*W];
    int cnt, p, kk;
    clear_mems();
    for (int i = 0; i < H*W; i++) used[i] = 1'b0;
    cnt = 0;
    while (cnt < nnz) begin
      p = $urandom_range(0, H*W-1);
      if (!used[p]) begin
        used[p] = 1'b1;
        cnt++;
      end
    end
    kk = $urandom_range(0, 5);
    ptr_mem[0] = 18'(kk);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (used[r*W+c]) begin
          col_mem[kk] = 10'(c);
          val_mem[kk] = 8'($urandom);
          kk++;
        end
      end
      ptr_mem[r+1] = 18'(kk);
    end
  endtask

  task automatic gen_messy();
    int p, idx;
    clear_mems();
    for (int i = 0; i < NZC; i++) col_mem[i] = 10'($urandom_range(0, 9));
    p = $urandom_range(0, 3);
    for (int r = 0; r <= H; r++) begin
      ptr_mem[r] = 18'(p);
      p += $urandom_range(0, 3);
    end
    idx = $urandom_range(1, H);
    ptr_mem[idx] = ($urandom_range(0, 1) == 0) ? 18'd90 : 18'($urandom_range(0, 20));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_decode(input bit rnd, input bit extra_start);
    bit got;
    build_expect();
    ready_rand = rnd;
    pulse_start();
    @(negedge clk);
    chk("err_cleared", 32'(err), 32'd0);
    if (extra_start) begin
      repeat (20) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      chk("err_flag", 32'(err), 32'(exp_err));
      chk("all_elements", 32'(exp_q.size()), 32'd0);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    logic [20:0] held;
    logic [20:0] act;
    bit          held_v;
    bit          want_done;
    item_t       e;
    held_v = 1'b0;
    want_done = 1'b0;
    forever begin
      @(negedge clk);
      act = {out_row, out_col, out_data, out_last};
      if (want_done) begin
        chk("done_pulse", 32'(done), 32'd1);
        want_done = 1'b0;
      end else if (done) begin
        chk("done_spurious", 32'(done), 32'd0);
      end
      if (held_v && reset) chk("stall_hold", 32'({out_valid, act}), 32'({1'b1, held}));
      held_v = 1'b0;
      if (reset && out_valid) begin
        if (!out_ready) begin
          held_v = 1'b1;
          held = act;
        end else begin
          hs_count++;
          if (exp_q.size() == 0) begin
            chk("unexpected_element", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("element", 32'(act), 32'(e));
            if (e.last) want_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  base;
    bit  got;
    reset = 1'b1;
    start = 1'b0;
    clear_mems();
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({ptr_addr, nz_addr, done, err}), 32'd0);
    chk("rst_out", 32'({out_valid, out_data, out_row, out_col, out_last}), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    clear_mems();   run_decode(1'b0, 1'b0);
    gen_identity(); run_decode(1'b0, 1'b0);
    gen_neg();      run_decode(1'b0, 1'b0);
    gen_sorted(20); run_decode(1'b0, 1'b0);
    run_decode(1'b1, 1'b0);
    gen_unsorted(); run_decode(1'b1, 1'b0);
    clear_mems();   run_decode(1'b1, 1'b1);

    // Reset in the middle of a decode, then a clean full decode.
    gen_sorted(20);
    build_expect();
    ready_rand = 1'b1;
    pulse_start();
    base = hs_count;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (hs_count - base >= 10) begin
        got = 1'b1;
        break;
      end
    end
    chk("ten_handshakes", 32'(got), 32'd1);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    exp_q.delete();
    chk("midrst_ctrl", 32'({ptr_addr, nz_addr, done, err}), 32'd0);
    chk("midrst_out", 32'({out_valid, out_data, out_row, out_col, out_last}), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    run_decode(1'b1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      gen_sorted($urandom_range(0, 40));
      run_decode(1'($urandom_range(0, 1)), 1'b0);
    end
    for (int t = 0; t < 6; t++) begin
      gen_messy();
      run_decode(1'b1, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
